fir_stream_ctrl: RTL and testbench
==================================

Name: fir_stream_ctrl

Overview:
- Upstream control stage for the bit-serial symmetric FIR core.
- Turns a parallel coefficient stream and a parallel sample stream (both valid/ready) into the core's bit-serial coefficient load, single-cycle start pulse and held sample, and manages lock.
- Captures the core's result on its done pulse and presents it downstream on a valid/ready port.
- Serialises core usage: never more than one operation in flight.

Parameters:
- BITS, 8, sample/coefficient/result width; must match the core.
- TAPS, 4, filter taps; the core holds TAPS/2 coefficients.
- TIMEOUT, 64, maximum cycles to wait for fir_done before aborting.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- coef_data  in  BITS  coefficient word
- coef_valid  in  1  coefficient word offered
- coef_ready  out  1  coefficient word accepted this cycle when high with coef_valid
- samp_data  in  BITS  input sample
- samp_valid  in  1  sample offered
- samp_ready  out  1  sample accepted when high with samp_valid
- res_data  out  BITS  filter result
- res_valid  out  1  result held until accepted
- res_ready  in  1  downstream accepts result
- lock_req  in  1  requested coefficient lock level
- coef_loaded  out  1  TAPS/2 words loaded since reset (sticky)
- timeout_err  out  1  sticky: core failed to finish within TIMEOUT
- fir_start  out  1  to core start
- fir_x  out  BITS  to core x
- fir_coeff_load_in  out  1  to core coeff_load_in
- fir_coeff_in  out  1  to core coeff_in
- fir_lock  out  1  to core lock
- fir_done  in  1  from core done
- fir_y  in  BITS  from core y

Behaviour:
- Reset: state IDLE; all outputs 0. Counters, shift register and lock register are cleared. The core must be reset in the same cycle; a reset mid-operation abandons everything with no result emitted.
- States: IDLE, COEF_SHIFT, START, WAIT_DONE, CAPTURE.
- IDLE, handshake readiness:
  - coef_ready = 1.
  - samp_ready = coef_loaded & !coef_valid & !res_valid. Coefficients have priority over samples.
  - Only one handshake can complete per cycle.
- IDLE, lock: fir_lock register <= lock_req every IDLE cycle. The lock level is frozen in all other states.
- Coefficient handshake: latch coef_data into the shift register and go to COEF_SHIFT.
- COEF_SHIFT:
  - Lasts exactly BITS cycles with fir_coeff_load_in=1.
  - fir_coeff_in = shift register MSB; shift left each cycle (MSB first).
  - After the BITS-th cycle: return to IDLE and increment the word counter modulo TAPS/2.
  - coef_loaded is set when the counter wraps to 0 for the first time.
  - The first word of a group of TAPS/2 lands in the core's highest coefficient slot. Words beyond TAPS/2 keep shifting and displace the oldest.
- Sample handshake: latch samp_data into fir_x and go to START.
- START: fir_start=1 for exactly one cycle, with fir_x stable. Then go to WAIT_DONE and clear the watchdog.
- fir_x holds its value until the next sample handshake.
- WAIT_DONE:
  - Watchdog increments each cycle.
  - fir_done=1 -> CAPTURE.
  - Watchdog reaches TIMEOUT-1 without done -> set timeout_err and go to IDLE; no result is emitted.
  - fir_done outside WAIT_DONE is ignored.
- CAPTURE: res_data <= fir_y, res_valid <= 1, go to IDLE. The core's accumulator is final one edge after done.
- Result port:
  - res_valid stays high and res_data stays stable until res_valid & res_ready.
  - res_valid clears on that edge; samp_ready can rise in the following cycle.
- Timing: sample handshake at edge t gives fir_start high in cycle t+1. With fir_done high in cycle n, res_valid is high from cycle n+2.
- fir_start and fir_coeff_load_in are mutually exclusive and never asserted outside START/COEF_SHIFT.

Test Plan:
- Reset, then 2 coefficient words 0x03, 0x05 (BITS=8, TAPS=4):
  - fir_coeff_in carries 00000011 then 00000101, each under 8 consecutive load cycles.
  - coef_loaded rises after the 16th shift cycle.
  - samp_ready stays 0 before that.
- After load, samples 0x01, 0x00, 0x00, 0x00, each with res_ready=1:
  - one fir_start pulse per sample with matching fir_x;
  - res_data equals the core's y each time;
  - res_valid rises exactly 2 cycles after fir_done.
- res_ready held 0 after the first result:
  - res_data/res_valid stay stable and samp_ready stays 0 for 20 cycles with samp_valid=1;
  - releasing res_ready accepts the next sample the cycle after.
- coef_valid and samp_valid both high in IDLE -> coefficient accepted first; the sample is accepted after COEF_SHIFT completes.
- Bench holds fir_done low -> after 64 WAIT_DONE cycles timeout_err=1, state IDLE, res_valid remains 0.
- lock_req toggled during WAIT_DONE -> fir_lock unchanged until IDLE; rst asserted mid COEF_SHIFT -> all outputs 0 the next cycle and coef_loaded cleared.

Source files
------------

// File: rtl/fir_stream_ctrl.sv
// Control stage in front of the bit-serial symmetric FIR core: serialises coefficient words,
// issues one start per accepted sample, and captures the result onto a valid/ready port.
module fir_stream_ctrl #(
  parameter int BITS    = 8,
  parameter int TAPS    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] coef_data,
  input  logic            coef_valid,
  output logic            coef_ready,
  input  logic [BITS-1:0] samp_data,
  input  logic            samp_valid,
  output logic            samp_ready,
  output logic [BITS-1:0] res_data,
  output logic            res_valid,
  input  logic            res_ready,
  input  logic            lock_req,
  output logic            coef_loaded,
  output logic            timeout_err,
  output logic            fir_start,
  output logic [BITS-1:0] fir_x,
  output logic            fir_coeff_load_in,
  output logic            fir_coeff_in,
  output logic            fir_lock,
  input  logic            fir_done,
  input  logic [BITS-1:0] fir_y
);

  localparam int NCOEF = TAPS / 2;
  localparam int BCW   = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int WCW   = (NCOEF > 1) ? $clog2(NCOEF) : 1;
  localparam int TCW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    COEF_SHIFT,
    START,
    WAIT_DONE,
    CAPTURE
  } state_t;

  state_t          state, state_nxt;
  logic [BITS-1:0] shreg;
  logic [BCW-1:0]  bit_cnt;
  logic [WCW-1:0]  word_cnt;
  logic [TCW-1:0]  wdog;
  logic            coef_hs, samp_hs, res_hs;
  logic            shift_last, word_wrap, wdog_exp;

  // Handshakes are only offered in IDLE and are suppressed while reset is asserted.
  assign coef_ready = (state == IDLE) && !rst;
  assign samp_ready = (state == IDLE) && !rst && coef_loaded && !coef_valid && !res_valid;
  assign coef_hs    = coef_valid && coef_ready;
  assign samp_hs    = samp_valid && samp_ready;
  assign res_hs     = res_valid && res_ready;

  assign shift_last = (bit_cnt == BCW'(BITS - 1));
  assign word_wrap  = (word_cnt == WCW'(NCOEF - 1));
  assign wdog_exp   = (wdog == TCW'(TIMEOUT - 1));

  always_comb begin
    state_nxt         = state;
    fir_start         = 1'b0;
    fir_coeff_load_in = 1'b0;
    fir_coeff_in      = 1'b0;
    unique case (state)
      IDLE: begin
        if (coef_hs) begin
          state_nxt = COEF_SHIFT;
        end else if (samp_hs) begin
          state_nxt = START;
        end
      end
      COEF_SHIFT: begin
        fir_coeff_load_in = 1'b1;
        fir_coeff_in      = shreg[BITS-1];
        if (shift_last) begin
          state_nxt = IDLE;
        end
      end
      START: begin
        fir_start = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (fir_done) begin
          state_nxt = CAPTURE;
        end else if (wdog_exp) begin
          state_nxt = IDLE;
        end
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      wdog        <= '0;
      coef_loaded <= 1'b0;
      timeout_err <= 1'b0;
      fir_lock    <= 1'b0;
      fir_x       <= '0;
      res_data    <= '0;
      res_valid   <= 1'b0;
    end else begin
      state <= state_nxt;

      // Lock level follows the request only while no operation is in progress.
      if (state == IDLE) begin
        fir_lock <= lock_req;
      end

      if (coef_hs) begin
        shreg   <= coef_data;
        bit_cnt <= '0;
      end else if (state == COEF_SHIFT) begin
        shreg   <= {shreg[BITS-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
        if (shift_last) begin
          word_cnt <= word_wrap ? '0 : word_cnt + 1'b1;
          if (word_wrap) begin
            coef_loaded <= 1'b1;
          end
        end
      end

      if (samp_hs) begin
        fir_x <= samp_data;
      end

      if (state == START) begin
        wdog <= '0;
      end else if (state == WAIT_DONE) begin
        wdog <= wdog + 1'b1;
        if (!fir_done && wdog_exp) begin
          timeout_err <= 1'b1;
        end
      end

      // The core's accumulator settles one edge after done, so capture happens in CAPTURE.
      if (res_hs) begin
        res_valid <= 1'b0;
      end
      if (state == CAPTURE) begin
        res_data  <= fir_y;
        res_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Bench for fir_stream_ctrl: a behavioural core rebuilds coefficients from the serial
// stream, and a scoreboard holds the expected result of every sample sent.
module tb_fir_stream_ctrl;

  localparam int BITS     = 8;
  localparam int TAPS     = 4;
  localparam int TIMEOUT  = 64;
  localparam int CORE_LAT = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [BITS-1:0] coef_data = '0;
  logic            coef_valid = 1'b0;
  logic            coef_ready;
  logic [BITS-1:0] samp_data = '0;
  logic            samp_valid = 1'b0;
  logic            samp_ready;
  logic [BITS-1:0] res_data;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic            lock_req = 1'b0;
  logic            coef_loaded, timeout_err;
  logic            fir_start, fir_coeff_load_in, fir_coeff_in, fir_lock;
  logic [BITS-1:0] fir_x;
  logic            fir_done;
  logic [BITS-1:0] fir_y;

  fir_stream_ctrl #(.BITS(BITS), .TAPS(TAPS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .coef_data(coef_data), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .samp_data(samp_data), .samp_valid(samp_valid), .samp_ready(samp_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .lock_req(lock_req), .coef_loaded(coef_loaded), .timeout_err(timeout_err),
    .fir_start(fir_start), .fir_x(fir_x), .fir_coeff_load_in(fir_coeff_load_in),
    .fir_coeff_in(fir_coeff_in), .fir_lock(fir_lock), .fir_done(fir_done), .fir_y(fir_y)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BITS-1:0] fir_ref(input logic [TAPS-1:0][BITS-1:0] dl,
                                              input logic [BITS-1:0] chi,
                                              input logic [BITS-1:0] clo);
    int acc;
    acc = int'(chi) * (int'(dl[0]) + int'(dl[3])) + int'(clo) * (int'(dl[1]) + int'(dl[2]));
    return acc[BITS-1:0];
  endfunction

  // Behavioural core
  logic [2*BITS-1:0]         core_coef;
  logic [TAPS-1:0][BITS-1:0] core_dl;
  logic [BITS-1:0]           core_res;
  int                        core_cnt;
  logic                      core_pend;
  logic                      suppress_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      core_coef <= '0;
      core_dl   <= '0;
      core_res  <= '0;
      core_cnt  <= 0;
      core_pend <= 1'b0;
      fir_done  <= 1'b0;
      fir_y     <= '0;
    end else begin
      fir_done <= 1'b0;
      if (fir_coeff_load_in) core_coef <= {core_coef[2*BITS-2:0], fir_coeff_in};
      if (fir_start) begin
        core_dl   <= {core_dl[TAPS-2:0], fir_x};
        core_res  <= fir_ref({core_dl[TAPS-2:0], fir_x}, core_coef[2*BITS-1:BITS], core_coef[BITS-1:0]);
        core_cnt  <= CORE_LAT;
        core_pend <= !suppress_done;
        fir_y     <= 8'hA5;
      end else if (core_pend) begin
        if (core_cnt == 0) begin
          fir_done  <= 1'b1;
          core_pend <= 1'b0;
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
      if (fir_done) fir_y <= core_res;
    end
  end

  // Expected-value model and scoreboard queues
  logic [TAPS-1:0][BITS-1:0] exp_dl = '0;
  logic [BITS-1:0]           exp_chi = '0, exp_clo = '0;
  logic [BITS-1:0]           exp_q[$];
  logic [BITS-1:0]           start_q[$];
  logic                      exp_bits[$];

  int   cyc = 0;
  int   done_cyc = -100;
  int   run = 0;
  logic res_valid_d = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      res_valid_d = 1'b0;
      run = 0;
    end else begin
      if (fir_coeff_load_in) begin
        run++;
        if (exp_bits.size() == 0) chk("coef_bit_extra", fir_coeff_load_in, 0);
        else chk("coef_bit", fir_coeff_in, exp_bits.pop_front());
      end else begin
        if (run != 0) chk("coef_run", run, BITS);
        run = 0;
      end
      if (fir_start) begin
        chk("start_excl", fir_coeff_load_in, 0);
        if (start_q.size() == 0) chk("start_extra", fir_start, 0);
        else chk("fir_x", fir_x, start_q.pop_front());
      end
      if (fir_done) done_cyc = cyc;
      if (res_valid && !res_valid_d) chk("res_lat", cyc - done_cyc, 2);
      res_valid_d = res_valid;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) chk("res_extra", res_valid, 0);
        else begin
          chk("res_data", res_data, exp_q.pop_front());
          chk("res_core_y", res_data, fir_y);
        end
      end
    end
  end

  task automatic push_coef(input logic [BITS-1:0] w);
    for (int i = BITS - 1; i >= 0; i--) exp_bits.push_back(w[i]);
    exp_chi = exp_clo;
    exp_clo = w;
  endtask

  task automatic push_samp(input logic [BITS-1:0] x, input logic push);
    exp_dl = {exp_dl[TAPS-2:0], x};
    start_q.push_back(x);
    if (push) exp_q.push_back(fir_ref(exp_dl, exp_chi, exp_clo));
  endtask

  task automatic send_coef(input logic [BITS-1:0] w, input logic prev_loaded, input logic exp_loaded);
    int n;
    coef_data = w;
    coef_valid = 1'b1;
    #1;
    n = 0;
    while (coef_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      chk("coef_hs_timeout", coef_ready, 1);
      coef_valid = 1'b0;
      return;
    end
    @(posedge clk);
    push_coef(w);
    #1 coef_valid = 1'b0;
    repeat (BITS) @(negedge clk);
    chk("coef_loaded_pre", coef_loaded, prev_loaded);
    @(negedge clk);
    chk("coef_loaded", coef_loaded, exp_loaded);
    chk("samp_ready_after_coef", samp_ready, exp_loaded);
  endtask

  task automatic send_sample(input logic [BITS-1:0] x, input logic push);
    int n;
    samp_data = x;
    samp_valid = 1'b1;
    #1;
    n = 0;
    while (samp_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      chk("samp_hs_timeout", samp_ready, 1);
      samp_valid = 1'b0;
      return;
    end
    @(posedge clk);
    push_samp(x, push);
    #1 samp_valid = 1'b0;
    @(negedge clk);
    chk("start_lat", fir_start, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (samp_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("idle_timeout", samp_ready, 1);
  endtask

  logic [BITS-1:0] held;
  logic [BITS-1:0] imp[4] = '{8'h01, 8'h00, 8'h00, 8'h00};

  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_coef_ready", coef_ready, 0);
    chk("rst_samp_ready", samp_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_coef_loaded", coef_loaded, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_fir_start", fir_start, 0);
    chk("rst_fir_x", fir_x, 0);
    chk("rst_load_in", fir_coeff_load_in, 0);
    chk("rst_coeff_in", fir_coeff_in, 0);
    chk("rst_fir_lock", fir_lock, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_coef_ready", coef_ready, 1);
    chk("unloaded_samp_ready", samp_ready, 0);

    send_coef(8'h03, 1'b0, 1'b0);
    send_coef(8'h05, 1'b0, 1'b1);

    // Impulse response with a free-flowing result port
    res_ready = 1'b1;
    foreach (imp[i]) send_sample(imp[i], 1'b1);
    wait_idle();

    // Stalled result port
    res_ready = 1'b0;
    send_sample(8'h02, 1'b1);
    n = 0;
    while (res_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("stall_res_arrive", res_valid, 1);
    held = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    samp_data = 8'h04;
    samp_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("stall_valid", res_valid, 1);
      chk("stall_data", res_data, held);
      chk("stall_samp_ready", samp_ready, 0);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("samp_after_release", samp_ready, 1);
    send_sample(8'h04, 1'b1);
    wait_idle();

    // Coefficient wins over a simultaneous sample
    coef_data = 8'h07;
    coef_valid = 1'b1;
    samp_data = 8'h01;
    samp_valid = 1'b1;
    #1;
    chk("prio_coef_ready", coef_ready, 1);
    chk("prio_samp_ready", samp_ready, 0);
    @(posedge clk);
    push_coef(8'h07);
    #1 coef_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (samp_ready !== 1'b1 && n < 50);
    chk("prio_samp_wait", n, BITS + 1);
    @(posedge clk);
    push_samp(8'h01, 1'b1);
    #1 samp_valid = 1'b0;
    @(negedge clk);
    chk("prio_start", fir_start, 1);
    wait_idle();

    // Lock level frozen outside IDLE
    lock_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("lock_idle_set", fir_lock, 1);
    send_sample(8'h03, 1'b1);
    @(negedge clk);
    lock_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("lock_frozen", fir_lock, 1);
    end
    wait_idle();
    @(negedge clk);
    chk("lock_idle_clear", fir_lock, 0);

    // Watchdog abort
    suppress_done = 1'b1;
    send_sample(8'h05, 1'b0);
    repeat (TIMEOUT) begin
      @(negedge clk);
      chk("to_pending", timeout_err, 0);
    end
    @(negedge clk);
    chk("timeout_err", timeout_err, 1);
    chk("to_idle", coef_ready, 1);
    chk("to_no_res", res_valid, 0);
    suppress_done = 1'b0;
    @(negedge clk);
    chk("to_sticky", timeout_err, 1);
    chk("sb_empty", exp_q.size(), 0);

    // Reset in the middle of a coefficient shift
    coef_data = 8'h09;
    coef_valid = 1'b1;
    #1;
    n = 0;
    while (coef_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk);
    push_coef(8'h09);
    #1 coef_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_bits.delete();
    start_q.delete();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("mrst_load_in", fir_coeff_load_in, 0);
    chk("mrst_coeff_in", fir_coeff_in, 0);
    chk("mrst_coef_loaded", coef_loaded, 0);
    chk("mrst_timeout_err", timeout_err, 0);
    chk("mrst_fir_x", fir_x, 0);
    chk("mrst_res_data", res_data, 0);
    chk("mrst_coef_ready", coef_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_coef_ready", coef_ready, 1);
    chk("post_rst_samp_ready", samp_ready, 0);
    chk("post_rst_loaded", coef_loaded, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete, checks %0d", checks);
    $fatal(1, "bench watchdog expired");
  end

endmodule
